// File: rtl/score_display_pkg.sv
// Shared types and constants for the score_display block: FSM encoding,
// double-dabble sizing, display register layout and 7-segment patterns.
package score_display_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int SHIFT_CYCLES = 10;
    localparam int BCD_DIGITS   = 3;
    localparam int CNT_W        = 4;
    localparam int MAG_W        = 10;

    // Active-high patterns, bit0 = a ... bit6 = g.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    typedef struct packed {
        logic                        sign;
        logic [BCD_DIGITS-1:0][3:0]  digit;   // [0] ones, [2] hundreds
        logic [BCD_DIGITS-1:0]       blank;
    } disp_t;

    localparam disp_t DISP_RESET = '{sign: 1'b0, digit: '0, blank: '1};

    function automatic disp_t make_disp(input logic sign,
                                        input logic [4*BCD_DIGITS-1:0] bcd,
                                        input logic blank_leading);
        disp_t d;
        d.sign     = sign;
        d.digit    = bcd;
        d.blank[0] = 1'b0;
        d.blank[1] = blank_leading && (bcd[11:4] == 8'd0);
        d.blank[2] = blank_leading && (bcd[11:8] == 4'd0);
        return d;
    endfunction

    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/score_digit_encoder.sv
// Combinational map from {digit, blank, minus} to one 7-segment pattern,
// with output polarity chosen by SEG_ACTIVE_LOW.
module score_digit_encoder
    import score_display_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg
);

    logic [6:0] pattern;

    // NOTE: every signal written in always_comb gets a value on every path
    // (here via the first assignment), otherwise a latch is inferred.
    always_comb begin
        pattern = seg_pattern(digit);
        if (minus) begin
            pattern = SEG_MINUS;
        end else if (blank) begin
            pattern = SEG_BLANK;
        end
    end

    assign seg = SEG_ACTIVE_LOW ? ~pattern : pattern;

endmodule

// File: rtl/score_display.sv
// Two-player signed score display: one shared serial double-dabble converter
// alternates between players and commits results into per-player registers.
module score_display
    import score_display_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [MAG_W-1:0] player1_score,
    input  logic [MAG_W-1:0] player2_score,
    output logic [6:0]       seg1,
    output logic [6:0]       seg2,
    output logic [6:0]       seg3,
    output logic [6:0]       seg4,
    output logic [6:0]       seg5,
    output logic [6:0]       seg6,
    output logic [6:0]       seg7,
    output logic [6:0]       seg8,
    output logic             disp_valid
);

    state_t                  state;
    logic                    player_sel;   // 0 = player 1, 1 = player 2
    logic                    sign;
    logic [MAG_W-1:0]        mag;
    logic [4*BCD_DIGITS-1:0] bcd;
    logic [CNT_W-1:0]        cnt;
    disp_t                   disp_p1;
    disp_t                   disp_p2;

    logic [MAG_W-1:0]        sel_score;
    logic [MAG_W-1:0]        load_mag;
    logic [4*BCD_DIGITS-1:0] bcd_adj;

    // A 10-bit unsigned magnitude holds 512, so -512 needs no special case.
    assign sel_score = player_sel ? player2_score : player1_score;
    assign load_mag  = sel_score[MAG_W-1] ? (~sel_score + 10'd1) : sel_score;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_LOAD;
            player_sel <= 1'b0;
            sign       <= 1'b0;
            mag        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            disp_p1    <= DISP_RESET;
            disp_p2    <= DISP_RESET;
            disp_valid <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    sign  <= sel_score[MAG_W-1];
                    mag   <= load_mag;
                    bcd   <= '0;
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    {bcd, mag} <= {bcd_adj[4*BCD_DIGITS-2:0], mag, 1'b0};
                    cnt        <= cnt + 1'b1;
                    if (cnt == CNT_W'(SHIFT_CYCLES - 1)) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (player_sel) begin
                        disp_p2    <= make_disp(sign, bcd, BLANK_LEADING);
                        disp_valid <= 1'b1;
                    end else begin
                        disp_p1 <= make_disp(sign, bcd, BLANK_LEADING);
                    end
                    player_sel <= ~player_sel;
                    state      <= ST_LOAD;
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    // Encoder slots: 0..2 player 1 ones..hundreds, 3 player 1 sign; 4..7 player 2.
    logic [7:0][3:0] enc_digit;
    logic [7:0]      enc_blank;
    logic [7:0]      enc_minus;
    logic [6:0]      enc_seg [8];

    assign enc_digit = {4'd0, disp_p2.digit, 4'd0, disp_p1.digit};
    assign enc_blank = {~disp_p2.sign, disp_p2.blank, ~disp_p1.sign, disp_p1.blank};
    assign enc_minus = {disp_p2.sign, 3'b000, disp_p1.sign, 3'b000};

    for (genvar g = 0; g < 8; g++) begin : g_enc
        score_digit_encoder #(
            .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
        ) u_enc (
            .digit(enc_digit[g]),
            .blank(enc_blank[g]),
            .minus(enc_minus[g]),
            .seg  (enc_seg[g])
        );
    end

    assign seg1 = enc_seg[0];
    assign seg2 = enc_seg[1];
    assign seg3 = enc_seg[2];
    assign seg4 = enc_seg[3];
    assign seg5 = enc_seg[4];
    assign seg6 = enc_seg[5];
    assign seg7 = enc_seg[6];
    assign seg8 = enc_seg[7];

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: directed corner cases, reset abort,
// then randomized passes checked against an arithmetic decimal model.
module tb_score_display;

    logic       clock;
    logic       resetn;
    logic [9:0] player1_score;
    logic [9:0] player2_score;
    logic [6:0] seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8;
    logic [6:0] aseg1, aseg2, aseg3, aseg4, aseg5, aseg6, aseg7, aseg8;
    logic       disp_valid;
    logic       adisp_valid;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] DIGIT_SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    score_display dut (
        .clock(clock), .resetn(resetn),
        .player1_score(player1_score), .player2_score(player2_score),
        .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4),
        .seg5(seg5), .seg6(seg6), .seg7(seg7), .seg8(seg8),
        .disp_valid(disp_valid)
    );

    // Second instance: active-high segments, no leading-zero blanking.
    score_display #(.SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b0)) dut_alt (
        .clock(clock), .resetn(resetn),
        .player1_score(player1_score), .player2_score(player2_score),
        .seg1(aseg1), .seg2(aseg2), .seg3(aseg3), .seg4(aseg4),
        .seg5(aseg5), .seg6(aseg6), .seg7(aseg7), .seg8(aseg8),
        .disp_valid(adisp_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Reference: pos 0 ones, 1 tens, 2 hundreds, 3 sign; shown=0 means all blank.
    function automatic logic [6:0] exp_seg(input int pos, input logic [9:0] score, input bit shown,
                                           input bit act_low, input bit blank_lead);
        int         v;
        int         mag;
        int         d;
        bit         blank;
        bit         minus;
        logic [6:0] pat;
        v     = int'($signed(score));
        mag   = (v < 0) ? -v : v;
        d     = 0;
        blank = 1'b0;
        minus = 1'b0;
        case (pos)
            0: d = mag % 10;
            1: begin d = (mag / 10) % 10; blank = blank_lead && (mag < 10);  end
            2: begin d = mag / 100;       blank = blank_lead && (mag < 100); end
            default: begin minus = (v < 0); blank = !minus; end
        endcase
        if (!shown) begin
            blank = 1'b1;
            minus = 1'b0;
        end
        pat = minus ? 7'h40 : (blank ? 7'h00 : DIGIT_SEG[d]);
        return act_low ? ~pat : pat;
    endfunction

    task automatic check_player(input int p, input logic [9:0] score, input bit shown, input string tag);
        logic [6:0] obs;
        logic [6:0] alt_obs;
        for (int pos = 0; pos < 4; pos++) begin
            case (p * 4 + pos)
                0:       begin obs = seg1; alt_obs = aseg1; end
                1:       begin obs = seg2; alt_obs = aseg2; end
                2:       begin obs = seg3; alt_obs = aseg3; end
                3:       begin obs = seg4; alt_obs = aseg4; end
                4:       begin obs = seg5; alt_obs = aseg5; end
                5:       begin obs = seg6; alt_obs = aseg6; end
                6:       begin obs = seg7; alt_obs = aseg7; end
                default: begin obs = seg8; alt_obs = aseg8; end
            endcase
            check($sformatf("%s_p%0d_pos%0d", tag, p + 1, pos), obs,
                  exp_seg(pos, score, shown, 1'b1, 1'b1));
            check($sformatf("%s_p%0d_pos%0d_alt", tag, p + 1, pos), alt_obs,
                  exp_seg(pos, score, shown, 1'b0, 1'b0));
        end
    endtask

    task automatic check_valid(input bit expected, input string tag);
        check({tag, "_valid"}, {6'd0, disp_valid}, {6'd0, expected});
        check({tag, "_valid_alt"}, {6'd0, adisp_valid}, {6'd0, expected});
    endtask

    function automatic logic [9:0] rand_score();
        case ($urandom_range(0, 7))
            0:       return 10'h200;
            1:       return 10'h1FF;
            2:       return 10'h000;
            3:       return 10'h3FF;
            default: return 10'($urandom);
        endcase
    endfunction

    logic [9:0] last [2];

    initial begin
        resetn        = 1'b0;
        player1_score = 10'd0;
        player2_score = 10'd511;
        #12;
        check_player(0, 10'd0, 1'b0, "reset");
        check_player(1, 10'd0, 1'b0, "reset");
        check_valid(1'b0, "reset");

        // Release: edge 1 is player 1 LOAD, edge 12 its COMMIT, edge 24 player 2's.
        @(negedge clock);
        resetn = 1'b1;
        tick(11);
        check_player(0, 10'd0, 1'b0, "pre_commit");
        tick(1);
        check_player(0, 10'd0, 1'b1, "zero");
        check_player(1, 10'd0, 1'b0, "p2_not_yet");
        check_valid(1'b0, "after_p1");
        tick(1);
        player1_score = 10'h200;
        player2_score = 10'h3F9;
        tick(11);
        check_player(1, 10'd511, 1'b1, "max");
        check_player(0, 10'd0, 1'b1, "p1_hold");
        check_valid(1'b1, "after_p2");

        tick(12);
        check_player(0, 10'h200, 1'b1, "min_neg");
        tick(12);
        check_player(1, 10'h3F9, 1'b1, "neg7");

        // Input change two cycles after player 1 LOAD must not affect that pass.
        player1_score = 10'd100;
        tick(3);
        player1_score = 10'd205;
        tick(9);
        check_player(0, 10'd100, 1'b1, "captured");
        tick(24);
        check_player(0, 10'd205, 1'b1, "next_pass");

        // Edge 85 is player 2 LOAD; reset lands in the fifth SHIFT cycle.
        tick(6);
        #2;
        resetn = 1'b0;
        #1;
        check_player(0, 10'd0, 1'b0, "mid_reset");
        check_player(1, 10'd0, 1'b0, "mid_reset");
        check_valid(1'b0, "mid_reset");
        player1_score = 10'd3;
        player2_score = 10'h39C;
        #10;
        @(negedge clock);
        resetn = 1'b1;
        tick(11);
        check_player(0, 10'd0, 1'b0, "no_early_commit");
        check_valid(1'b0, "no_early_commit");
        tick(1);
        check_player(0, 10'd3, 1'b1, "post_reset");
        tick(12);
        check_player(1, 10'h39C, 1'b1, "post_reset");
        check_valid(1'b1, "post_reset");

        last[0] = 10'd3;
        last[1] = 10'h39C;
        for (int pass = 0; pass < 830; pass++) begin
            int         p;
            logic [9:0] v;
            p = pass % 2;
            v = rand_score();
            if (p == 0) player1_score = v; else player2_score = v;
            tick(1);
            if (p == 0) player1_score = rand_score(); else player2_score = rand_score();
            tick(11);
            last[p] = v;
            check_player(p, last[p], 1'b1, "rand");
            check_player(1 - p, last[1 - p], 1'b1, "rand_other");
            check_valid(1'b1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
